// File: rtl/univ_shift_reg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// univ_shift_reg
//
// Parametrised universal register. It replaces the old fixed 8-bit
// parallel-load register. It supports:
//   - hold, parallel load and clear
//   - shift left/right with serial inputs
//   - rotate left/right
//   - arithmetic shift right
//   - a counted burst-shift engine with a busy/done handshake
//
// Optional feature macro: UNIV_SHREG_PARITY_EN
//   When this macro is defined, the module adds a 'parity' output.
//   It is the XOR reduction of q (even parity) and is combinational.
//
// Parameters:
//   WIDTH     register width in bits (>= 2)
//   CNT_W     width of shift_amt and of the burst counter
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        gates every register update, including burst steps
//   mode      000 hold, 001 load, 010 shl, 011 shr,
//             100 rotl, 101 rotr, 110 asr, 111 clear
//   data_in   parallel load value
//   ser_in_l  bit entering at the LSB on shl
//   ser_in_r  bit entering at the MSB on shr
//   start     begins a burst; only looked at in IDLE
//   shift_amt number of burst steps
//   q         register contents
//   ser_out   bit most recently shifted or rotated out (registered)
//   busy      burst in progress (state RUN)
//   done      one-cycle burst-complete pulse (state DONE)
//   parity    even parity of q (only with UNIV_SHREG_PARITY_EN)
// ---------------------------------------------------------------------------
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_amt,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
`ifdef UNIV_SHREG_PARITY_EN
  ,
  output logic             parity
`endif
);

  // Operating modes, encoded exactly as they appear on the mode input.
  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROTL  = 3'b100,
    MODE_ROTR  = 3'b101,
    MODE_ASR   = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  // States of the burst engine.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q;
  mode_e              burstMode_q;
  logic [CNT_W-1:0]   shiftCnt_q;
  logic [WIDTH-1:0]   q_q;
  logic               serOut_q;
  logic               busy_q;
  logic               done_q;

  mode_e              stepMode;
  logic [WIDTH-1:0]   q_d;
  logic               serOut_d;
  logic               serOutUpdate;
  logic               liveIsShift;
  logic               lastStep;

  // Choose the mode for one step.
  //   - During a burst, use the mode latched at start.
  //   - Otherwise, use the live mode input.
  assign stepMode = (state_q == ST_RUN) ? burstMode_q : mode_e'(mode);

  // Only the shift and rotate modes (010..110) can start a real burst.
  // Any other mode finishes straight away through DONE.
  assign liveIsShift = (mode >= 3'b010) && (mode <= 3'b110);

  // This is the final step when the counter is about to reach zero.
  assign lastStep = (shiftCnt_q == CNT_W'(1));

  // One step of the register.
  // serOutUpdate is high only for modes that move a bit out of the word.
  always_comb begin
    q_d          = q_q;
    serOut_d     = serOut_q;
    serOutUpdate = 1'b0;
    case (stepMode)
      MODE_HOLD: begin
        q_d = q_q;
      end
      MODE_LOAD: begin
        q_d = data_in;
      end
      MODE_SHL: begin
        q_d          = {q_q[WIDTH-2:0], ser_in_l};
        serOut_d     = q_q[WIDTH-1];
        serOutUpdate = 1'b1;
      end
      MODE_SHR: begin
        q_d          = {ser_in_r, q_q[WIDTH-1:1]};
        serOut_d     = q_q[0];
        serOutUpdate = 1'b1;
      end
      MODE_ROTL: begin
        q_d          = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        serOut_d     = q_q[WIDTH-1];
        serOutUpdate = 1'b1;
      end
      MODE_ROTR: begin
        q_d          = {q_q[0], q_q[WIDTH-1:1]};
        serOut_d     = q_q[0];
        serOutUpdate = 1'b1;
      end
      MODE_ASR: begin
        q_d          = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        serOut_d     = q_q[0];
        serOutUpdate = 1'b1;
      end
      MODE_CLEAR: begin
        q_d = '0;
      end
      default: begin
        q_d = q_q;
      end
    endcase
  end

  // Burst FSM and datapath registers.
  //
  // done_q defaults to low every cycle, so the DONE pulse lasts exactly
  // one cycle even when en is low.
  //
  // A start in IDLE takes priority over a single step. On that edge the
  // FSM latches the mode and count, but q is left unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      burstMode_q <= MODE_HOLD;
      shiftCnt_q  <= '0;
      q_q         <= '0;
      serOut_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            if (start) begin
              if (liveIsShift && (shift_amt != '0)) begin
                state_q     <= ST_RUN;
                burstMode_q <= mode_e'(mode);
                shiftCnt_q  <= shift_amt;
                busy_q      <= 1'b1;
              end else begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            end else begin
              q_q <= q_d;
              if (serOutUpdate) begin
                serOut_q <= serOut_d;
              end
            end
          end
        end
        ST_RUN: begin
          if (en) begin
            q_q        <= q_d;
            serOut_q   <= serOut_d;
            shiftCnt_q <= shiftCnt_q - CNT_W'(1);
            if (lastStep) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q       = q_q;
  assign ser_out = serOut_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef UNIV_SHREG_PARITY_EN
  // Even parity over the current register contents.
  assign parity = ^q_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_univ_shift_reg
//
// Directed testbench for univ_shift_reg with WIDTH=8 and CNT_W=4.
// Single-step operations come from a vector table. The burst, stall,
// reset and zero-length cases use hand-written sequences.
// ---------------------------------------------------------------------------
module tb_univ_shift_reg;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] mode;
  logic [7:0] data_in;
  logic       ser_in_l;
  logic       ser_in_r;
  logic       start;
  logic [3:0] shift_amt;
  logic [7:0] q;
  logic       ser_out;
  logic       busy;
  logic       done;
`ifdef UNIV_SHREG_PARITY_EN
  logic       parity;
`endif

  int checkCount;
  int errorCount;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROTL  = 3'b100;
  localparam logic [2:0] M_ROTR  = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  typedef struct {
    logic [2:0] mode;
    logic [7:0] din;
    logic       sl;
    logic       sr;
    logic       en;
    logic [7:0] expQ;
    logic       expSer;
  } vec_t;

  vec_t vecs[17];

  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .data_in   (data_in),
    .ser_in_l  (ser_in_l),
    .ser_in_r  (ser_in_r),
    .start     (start),
    .shift_amt (shift_amt),
    .q         (q),
    .ser_out   (ser_out),
    .busy      (busy),
    .done      (done)
`ifdef UNIV_SHREG_PARITY_EN
    ,
    .parity    (parity)
`endif
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Compare one value against its expected value and update the counters.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one set of inputs at the falling edge.
  // Sample the outputs 1 ns after the next rising edge.
  task automatic applyStimulus(input logic [2:0] m, input logic [7:0] din,
                               input logic sl, input logic sr, input logic e);
    @(negedge clk);
    mode     = m;
    data_in  = din;
    ser_in_l = sl;
    ser_in_r = sr;
    en       = e;
    start    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Run one burst and collect statistics:
  //   - count the cycles with busy high
  //   - count the done pulses
  //   - capture q and ser_out while done is high
  // Inside the loop:
  //   - en is dropped for stallLen edges starting at loop index stallAt
  //   - start is re-asserted once during the run; it must be ignored
  //   - mode is switched to clear after the start edge; it must be ignored
  // The loop is bounded to 40 edges.
  task automatic runBurst(input logic [2:0] m, input logic [3:0] amt,
                          input logic [7:0] qBefore,
                          input int stallAt, input int stallLen,
                          output int busyCycles, output int doneCycles,
                          output logic [7:0] qAtDone, output logic serAtDone);
    bit finished;
    finished   = 1'b0;
    qAtDone    = 8'hxx;
    serAtDone  = 1'bx;
    @(negedge clk);
    mode      = m;
    shift_amt = amt;
    start     = 1'b1;
    en        = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("q_on_start_edge", {24'd0, q}, {24'd0, qBefore});
    start      = 1'b0;
    mode       = M_CLEAR;
    busyCycles = busy ? 1 : 0;
    doneCycles = 0;
    if (done) begin
      doneCycles = 1;
      qAtDone    = q;
      serAtDone  = ser_out;
    end
    for (int i = 0; i < 40 && !finished; i++) begin
      @(negedge clk);
      en    = !((i >= stallAt) && (i < stallAt + stallLen));
      start = (i == 1);
      @(posedge clk);
      #1;
      if (busy) busyCycles++;
      if (done) begin
        doneCycles++;
        qAtDone   = q;
        serAtDone = ser_out;
      end else if (doneCycles > 0 && !busy) begin
        finished = 1'b1;
      end
    end
    if (!finished) begin
      checkOutput("burst_timeout", 32'd1, 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    mode  = M_HOLD;
    en    = 1'b1;
  endtask

  initial begin
    int         busyCycles;
    int         doneCycles;
    int         doneSeen;
    logic [7:0] qAtDone;
    logic       serAtDone;

    checkCount = 0;
    errorCount = 0;
    clk        = 1'b0;
    rst_n      = 1'b0;
    en         = 1'b0;
    mode       = M_HOLD;
    data_in    = 8'h00;
    ser_in_l   = 1'b0;
    ser_in_r   = 1'b0;
    start      = 1'b0;
    shift_amt  = 4'd0;

    // Single-step vectors, applied in order starting from the reset state.
    vecs[0]  = '{M_LOAD,  8'h96, 1'b0, 1'b0, 1'b1, 8'h96, 1'b0};
    vecs[1]  = '{M_LOAD,  8'hFF, 1'b0, 1'b0, 1'b0, 8'h96, 1'b0};
    vecs[2]  = '{M_LOAD,  8'h81, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0};
    vecs[3]  = '{M_SHL,   8'h00, 1'b1, 1'b0, 1'b1, 8'h03, 1'b1};
    vecs[4]  = '{M_LOAD,  8'h80, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1};
    vecs[5]  = '{M_ASR,   8'h00, 1'b0, 1'b0, 1'b1, 8'hC0, 1'b0};
    vecs[6]  = '{M_SHR,   8'h00, 1'b0, 1'b1, 1'b1, 8'hE0, 1'b0};
    vecs[7]  = '{M_ROTL,  8'h00, 1'b0, 1'b0, 1'b1, 8'hC1, 1'b1};
    vecs[8]  = '{M_ROTR,  8'h00, 1'b0, 1'b0, 1'b1, 8'hE0, 1'b1};
    vecs[9]  = '{M_HOLD,  8'h55, 1'b0, 1'b0, 1'b1, 8'hE0, 1'b1};
    vecs[10] = '{M_SHR,   8'h00, 1'b0, 1'b0, 1'b0, 8'hE0, 1'b1};
    vecs[11] = '{M_CLEAR, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1};
    vecs[12] = '{M_SHL,   8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[13] = '{M_LOAD,  8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0};
    vecs[14] = '{M_SHR,   8'h00, 1'b0, 1'b0, 1'b1, 8'h2D, 1'b0};
    vecs[15] = '{M_ASR,   8'h00, 1'b0, 1'b0, 1'b1, 8'h16, 1'b1};
    vecs[16] = '{M_ROTL,  8'h00, 1'b0, 1'b0, 1'b1, 8'h2C, 1'b0};

    // Release reset, load 0xA5, then assert reset between clock edges.
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(M_LOAD, 8'hA5, 1'b0, 1'b0, 1'b1);
    checkOutput("load_a5", {24'd0, q}, 32'hA5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_q", {24'd0, q}, 32'h00);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_ser", {31'd0, ser_out}, 32'd0);
`ifdef UNIV_SHREG_PARITY_EN
    checkOutput("reset_parity", {31'd0, parity}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Single-step table.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].din, vecs[i].sl, vecs[i].sr, vecs[i].en);
      checkOutput($sformatf("vec%0d_q", i), {24'd0, q}, {24'd0, vecs[i].expQ});
      checkOutput($sformatf("vec%0d_ser", i), {31'd0, ser_out}, {31'd0, vecs[i].expSer});
      checkOutput($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
`ifdef UNIV_SHREG_PARITY_EN
      checkOutput($sformatf("vec%0d_parity", i), {31'd0, parity}, {31'd0, ^vecs[i].expQ});
`endif
    end

    // rotr burst of 3 starting from 0xB4: B4 -> 5A -> 2D -> 96.
    applyStimulus(M_LOAD, 8'hB4, 1'b0, 1'b0, 1'b1);
    runBurst(M_ROTR, 4'd3, 8'hB4, 100, 0, busyCycles, doneCycles, qAtDone, serAtDone);
    checkOutput("rotr3_busy_cycles", busyCycles, 32'd3);
    checkOutput("rotr3_done_pulses", doneCycles, 32'd1);
    checkOutput("rotr3_q", {24'd0, qAtDone}, 32'h96);
    checkOutput("rotr3_ser", {31'd0, serAtDone}, 32'd1);
    checkOutput("rotr3_q_after", {24'd0, q}, 32'h96);

    // Same burst, but en is low for 2 cycles in the middle.
    applyStimulus(M_LOAD, 8'hB4, 1'b0, 1'b0, 1'b1);
    runBurst(M_ROTR, 4'd3, 8'hB4, 1, 2, busyCycles, doneCycles, qAtDone, serAtDone);
    checkOutput("stall_busy_cycles", busyCycles, 32'd5);
    checkOutput("stall_done_pulses", doneCycles, 32'd1);
    checkOutput("stall_q", {24'd0, qAtDone}, 32'h96);

    // shift_amt larger than WIDTH: shl 10 times with ser_in_l=1 fills q with ones.
    applyStimulus(M_CLEAR, 8'h00, 1'b1, 1'b0, 1'b1);
    runBurst(M_SHL, 4'd10, 8'h00, 100, 0, busyCycles, doneCycles, qAtDone, serAtDone);
    checkOutput("long_busy_cycles", busyCycles, 32'd10);
    checkOutput("long_q", {24'd0, qAtDone}, 32'hFF);
    checkOutput("long_ser", {31'd0, serAtDone}, 32'd1);

    // shl burst of 6 from 0x0F, with reset pulsed low after step 2.
    applyStimulus(M_LOAD, 8'h0F, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    mode      = M_SHL;
    shift_amt = 4'd6;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("rst_burst_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_burst_step2_q", {24'd0, q}, 32'h3C);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midburst_reset_q", {24'd0, q}, 32'h00);
    checkOutput("midburst_reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midburst_reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mode  = M_HOLD;
    doneSeen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) doneSeen++;
    end
    checkOutput("no_done_after_reset", doneSeen, 32'd0);

    // Zero-length start: no busy, done on the next cycle, q unchanged.
    applyStimulus(M_LOAD, 8'h3C, 1'b0, 1'b0, 1'b1);
    runBurst(M_SHL, 4'd0, 8'h3C, 100, 0, busyCycles, doneCycles, qAtDone, serAtDone);
    checkOutput("zero_busy_cycles", busyCycles, 32'd0);
    checkOutput("zero_done_pulses", doneCycles, 32'd1);
    checkOutput("zero_q", {24'd0, qAtDone}, 32'h3C);

    // Start with a non-shift mode: goes straight to done and does not load.
    data_in = 8'h11;
    runBurst(M_LOAD, 4'd5, 8'h3C, 100, 0, busyCycles, doneCycles, qAtDone, serAtDone);
    checkOutput("nonshift_busy_cycles", busyCycles, 32'd0);
    checkOutput("nonshift_done_pulses", doneCycles, 32'd1);
    checkOutput("nonshift_q", {24'd0, q}, 32'h3C);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
